// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter, dmem_arb_pick).
package dmem_arbiter_pkg;

    localparam int unsigned ISIZE        = 16;
    localparam int unsigned DSIZE        = 32;
    localparam int unsigned ARB_MAX_WAIT = 4;
    localparam int unsigned WCNT_W       = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_XFER_C = 2'd1,
        ARB_XFER_A = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_C    = 2'd1,
        GNT_A    = 2'd2
    } arb_grant_e;

    // Starvation counter: cleared when A wins, bumped (saturating) each time A loses to C.
    function automatic logic [WCNT_W-1:0] wait_cnt_next(
        input logic [WCNT_W-1:0] cnt,
        input arb_grant_e        grant,
        input logic              aux_req,
        input logic [WCNT_W-1:0] max_wait
    );
        logic [WCNT_W-1:0] nxt;
        nxt = cnt;
        if (grant == GNT_A) begin
            nxt = '0;
        end else if ((grant == GNT_C) && aux_req && (cnt < max_wait)) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for dmem_arbiter.
// DMEM_ARB_RR_EN selects strict alternation; otherwise CPU priority with a starvation counter.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              cpu_req_i,
    input  logic              aux_req_i,
`ifdef DMEM_ARB_RR_EN
    input  logic              last_grant_a_i,
`else
    input  logic [WCNT_W-1:0] wait_cnt_i,
`endif
    output arb_grant_e        grant_o
);

    logic aux_wins_tie;

`ifdef DMEM_ARB_RR_EN
    assign aux_wins_tie = ~last_grant_a_i;
`else
    assign aux_wins_tie = (wait_cnt_i == WCNT_W'(MAX_WAIT));
`endif

    always_comb begin
        grant_o = GNT_NONE;
        if (cpu_req_i && aux_req_i) begin
            grant_o = aux_wins_tie ? GNT_A : GNT_C;
        end else if (cpu_req_i) begin
            grant_o = GNT_C;
        end else if (aux_req_i) begin
            grant_o = GNT_A;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between CPU MEM stage (C) and auxiliary master (A).
// Optional macro DMEM_ARB_RR_EN: round-robin on contention instead of CPU priority + starvation counter.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = ISIZE,
    parameter int unsigned DW       = DSIZE,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_ack,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          aux_ack_q, aux_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] aux_rdata_q, aux_rdata_d;
    arb_grant_e    grant;
    logic          arb_en;

    assign arb_en = (state_q == ARB_IDLE) || (state_q == ARB_DONE);

`ifdef DMEM_ARB_RR_EN
    logic last_grant_a_q, last_grant_a_d;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .cpu_req_i      (cpu_req),
        .aux_req_i      (aux_req),
        .last_grant_a_i (last_grant_a_q),
        .grant_o        (grant)
    );

    always_comb begin
        last_grant_a_d = last_grant_a_q;
        if (arb_en && (grant != GNT_NONE)) begin
            last_grant_a_d = (grant == GNT_A);
        end
    end

    // Reset to "A granted last" so the CPU wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_a_q <= 1'b1;
        end else begin
            last_grant_a_q <= last_grant_a_d;
        end
    end
`else
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .cpu_req_i  (cpu_req),
        .aux_req_i  (aux_req),
        .wait_cnt_i (wait_cnt_q),
        .grant_o    (grant)
    );

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (arb_en) begin
            wait_cnt_d = wait_cnt_next(wait_cnt_q, grant, aux_req, WCNT_W'(MAX_WAIT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cpu_ack_d   = 1'b0;
        aux_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        unique case (state_q)
            ARB_IDLE, ARB_DONE: begin
                case (grant)
                    GNT_C:   state_d = ARB_XFER_C;
                    GNT_A:   state_d = ARB_XFER_A;
                    default: state_d = ARB_IDLE;
                endcase
            end
            ARB_XFER_C: begin
                state_d   = ARB_DONE;
                cpu_ack_d = 1'b1;
                if (!cpu_we) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            ARB_XFER_A: begin
                state_d   = ARB_DONE;
                aux_ack_d = 1'b1;
                if (!aux_we) begin
                    aux_rdata_d = mem_rdata;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A reset landing in an XFER cycle drops the access: no ack, no rdata update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            cpu_ack_q   <= 1'b0;
            aux_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ack_q   <= cpu_ack_d;
            aux_ack_q   <= aux_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ARB_XFER_C: begin
                mem_write = cpu_we & ~rst;
                mem_read  = ~cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            ARB_XFER_A: begin
                mem_write = aux_we & ~rst;
                mem_read  = ~aux_we;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_ack   = cpu_ack_q;
    assign aux_ack   = aux_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign aux_rdata = aux_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          aux_req, aux_we, aux_ack;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata, aux_rdata;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_ack   (aux_ack),
        .aux_rdata (aux_rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: unwritten words return a fixed pattern of their address.
    function automatic logic [31:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a ^ 16'h5A00, ~a};
    endfunction

    logic [31:0]  mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end
    assign mem_rdata = written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr);

    logic [31:0] ref_mem [256];

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
        checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL rst_aux_ack: got %b want 0", aux_ack); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
        checks++; if (aux_rdata !== 32'h0) begin errors++; $display("FAIL rst_aux_rdata: got %h want 0", aux_rdata); end
        checks++; if ({mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL rst_mem: got w=%b r=%b a=%h d=%h want all 0", mem_write, mem_read, mem_addr, mem_wdata);
        end
        cpu_req = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", cpu_stall); end
        do_reset();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL t1_stall_c0: got %b want 1", cpu_stall); end
        @(posedge clk); #1;
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL t1_memrd: got r=%b w=%b want r=1 w=0", mem_read, mem_write); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL t1_addr: got %h want 0010", mem_addr); end
        checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL t1_c1: got stall=%b ack=%b want 1/0", cpu_stall, cpu_ack); end
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL t1_ack: got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata: got %h want deadbeef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL t1_stall_c2: got %b want 0", cpu_stall); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t1_c3: got ack=%b rd=%b want 0/0", cpu_ack, mem_read); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_hold: got %h want deadbeef", cpu_rdata); end
    endtask

    task automatic test_aux_write_cpu_read();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (aux_ack !== 1'b1 || aux_rdata !== init_val(16'h0011)) begin
            errors++; $display("FAIL t2_aux_rd: got ack=%b d=%h want 1/%h", aux_ack, aux_rdata, init_val(16'h0011));
        end
        aux_we = 1'b1; aux_addr = 16'h0020; aux_wdata = 32'h12345678;
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 16'h0020 || mem_wdata !== 32'h12345678) begin
            errors++; $display("FAIL t2_wr_bus: got w=%b r=%b a=%h d=%h want 1/0/0020/12345678", mem_write, mem_read, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        checks++; if (aux_ack !== 1'b1 || aux_rdata !== init_val(16'h0011)) begin
            errors++; $display("FAIL t2_aux_wr_ack: got ack=%b d=%h want 1/%h", aux_ack, aux_rdata, init_val(16'h0011));
        end
        ref_mem[8'h20] = 32'h12345678;
        aux_req = 1'b0; aux_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            errors++; $display("FAIL t2_cpu_rd: got ack=%b d=%h want 1/12345678", cpu_ack, cpu_rdata);
        end
        checks++; if (aux_rdata !== init_val(16'h0011)) begin errors++; $display("FAIL t2_aux_keep: got %h want %h", aux_rdata, init_val(16'h0011)); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_xfer();
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0030; aux_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL t5_pre_wr: got %b want 1", mem_write); end
        rst = 1'b1;
        aux_req = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL t5_wr_gated: got %b want 0", mem_write); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL t5_no_ack: got %b want 0", aux_ack); end
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t5_idle: got w=%b r=%b want 0/0", mem_write, mem_read); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== ref_mem[8'h30]) begin
            errors++; $display("FAIL t5_mem_kept: got ack=%b d=%h want 1/%h", cpu_ack, cpu_rdata, ref_mem[8'h30]);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0008;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            checks++; if (cpu_ack !== ((cyc % 2) == 0)) begin errors++; $display("FAIL t6_ack_c%0d: got %b want %b", cyc, cpu_ack, (cyc % 2) == 0); end
            checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL t6_aux_c%0d: got %b want 0", cyc, aux_ack); end
            if ((cyc % 2) == 0) begin
                checks++; if (cpu_rdata !== ref_mem[cpu_addr[7:0]]) begin errors++; $display("FAIL t6_rdata_%0d: got %h want %h", n, cpu_rdata, ref_mem[cpu_addr[7:0]]); end
                n++;
                cpu_addr = cpu_addr + 16'd1;
                if (n == 5) cpu_req = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic exp_a;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0002;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            int i;
            @(posedge clk); #1;
            i = (cyc - 1) / 2;
`ifdef DMEM_ARB_RR_EN
            exp_a = (i % 2) == 1;
`else
            exp_a = (i % (MAXW + 1)) == MAXW;
`endif
            if ((cyc % 2) == 1) begin
                checks++; if (mem_addr !== (exp_a ? 16'h0002 : 16'h0001)) begin
                    errors++; $display("FAIL cont_grant_%0d: got addr %h want %h", i, mem_addr, exp_a ? 16'h0002 : 16'h0001);
                end
            end else begin
                checks++; if (cpu_ack !== !exp_a || aux_ack !== exp_a) begin
                    errors++; $display("FAIL cont_ack_%0d: got c=%b a=%b want c=%b a=%b", i, cpu_ack, aux_ack, !exp_a, exp_a);
                end
            end
        end
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        m_busy, m_port_a, n_cpu_ack, n_aux_ack, e_cpu_ack, e_aux_ack, win_c, win_a;
        logic [31:0] e_cpu_rdata, e_aux_rdata;
        int          losses, aux_seen_cpu_acks;
        logic        last_a;
        do_reset();
        m_busy = 1'b0; m_port_a = 1'b0; e_cpu_ack = 1'b0; e_aux_ack = 1'b0;
        e_cpu_rdata = '0; e_aux_rdata = '0; losses = 0; last_a = 1'b1; aux_seen_cpu_acks = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++; if (cpu_ack !== e_cpu_ack || aux_ack !== e_aux_ack) begin
                errors++; $display("FAIL rnd_ack_c%0d: got c=%b a=%b want c=%b a=%b", cyc, cpu_ack, aux_ack, e_cpu_ack, e_aux_ack);
            end
            checks++; if (cpu_rdata !== e_cpu_rdata || aux_rdata !== e_aux_rdata) begin
                errors++; $display("FAIL rnd_rdata_c%0d: got c=%h a=%h want c=%h a=%h", cyc, cpu_rdata, aux_rdata, e_cpu_rdata, e_aux_rdata);
            end
            if (aux_req && cpu_ack) aux_seen_cpu_acks++;
            if (aux_ack) begin
`ifdef DMEM_ARB_RR_EN
                checks++; if (aux_seen_cpu_acks > 2) begin errors++; $display("FAIL rnd_aux_wait_c%0d: got %0d cpu acks want <=2", cyc, aux_seen_cpu_acks); end
`else
                checks++; if (aux_seen_cpu_acks > MAXW + 1) begin errors++; $display("FAIL rnd_aux_wait_c%0d: got %0d cpu acks want <=%0d", cyc, aux_seen_cpu_acks, MAXW + 1); end
`endif
                aux_seen_cpu_acks = 0;
            end
            if ((e_cpu_ack && $urandom_range(0, 1) == 0) || (!e_cpu_ack && !cpu_req && $urandom_range(0, 2) == 0)) begin
                cpu_req = 1'b1; cpu_we = ($urandom_range(0, 2) == 0);
                cpu_addr = 16'($urandom_range(0, 63)); cpu_wdata = $urandom;
            end else if (e_cpu_ack) begin
                cpu_req = 1'b0;
            end
            if ((e_aux_ack && $urandom_range(0, 1) == 0) || (!e_aux_ack && !aux_req && $urandom_range(0, 2) == 0)) begin
                aux_req = 1'b1; aux_we = ($urandom_range(0, 1) == 0);
                aux_addr = 16'($urandom_range(0, 63)); aux_wdata = $urandom;
            end else if (e_aux_ack) begin
                aux_req = 1'b0;
            end
            #1;
            checks++; if (cpu_stall !== (cpu_req && !e_cpu_ack)) begin errors++; $display("FAIL rnd_stall_c%0d: got %b want %b", cyc, cpu_stall, cpu_req && !e_cpu_ack); end
            if (m_busy) begin
                checks++; if (mem_write !== (m_port_a ? aux_we : cpu_we) || mem_read !== !(m_port_a ? aux_we : cpu_we) ||
                              mem_addr !== (m_port_a ? aux_addr : cpu_addr) || mem_wdata !== (m_port_a ? aux_wdata : cpu_wdata)) begin
                    errors++; $display("FAIL rnd_bus_c%0d: got w=%b r=%b a=%h d=%h for port %s", cyc, mem_write, mem_read, mem_addr, mem_wdata, m_port_a ? "A" : "C");
                end
            end else begin
                checks++; if ({mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
                    errors++; $display("FAIL rnd_bus_idle_c%0d: got w=%b r=%b a=%h d=%h want all 0", cyc, mem_write, mem_read, mem_addr, mem_wdata);
                end
            end
            n_cpu_ack = 1'b0; n_aux_ack = 1'b0;
            if (m_busy) begin
                if (m_port_a) begin
                    if (aux_we) ref_mem[aux_addr[7:0]] = aux_wdata; else e_aux_rdata = ref_mem[aux_addr[7:0]];
                    n_aux_ack = 1'b1;
                end else begin
                    if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata; else e_cpu_rdata = ref_mem[cpu_addr[7:0]];
                    n_cpu_ack = 1'b1;
                end
                m_busy = 1'b0;
            end else begin
                win_a = 1'b0; win_c = 1'b0;
                if (cpu_req && aux_req) begin
`ifdef DMEM_ARB_RR_EN
                    win_a = !last_a;
`else
                    win_a = (losses == MAXW);
`endif
                    win_c = !win_a;
                end else begin
                    win_c = cpu_req;
                    win_a = aux_req;
                end
                if (win_a) losses = 0;
                else if (win_c && aux_req && losses < MAXW) losses++;
                if (win_a || win_c) begin
                    last_a = win_a;
                    m_busy = 1'b1;
                    m_port_a = win_a;
                end
            end
            e_cpu_ack = n_cpu_ack; e_aux_ack = n_aux_ack;
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(16'(i));
        test_reset();
        test_cpu_read();
        test_aux_write_cpu_read();
        test_reset_in_xfer();
        test_back_to_back();
        test_contention();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
